// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default geometry, the
// writeback entry record and a helper sizing the flattened FIFO entry.
package wb_arbiter_pkg;

  localparam int INST_ID_BITS_DEF = 6;
  localparam int PRN_BITS_DEF     = 6;
  localparam int MAX_OPERANDS_DEF = 3;
  localparam int FU_COUNT_DEF     = 4;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int DATA_BITS        = 64;

  // One buffered FU result at the default geometry.
  typedef struct packed {
    logic [INST_ID_BITS_DEF-1:0]                      inst_id;
    logic [MAX_OPERANDS_DEF-1:0][PRN_BITS_DEF-1:0]    prn;
    logic [MAX_OPERANDS_DEF-1:0][DATA_BITS-1:0]       data;
    logic [MAX_OPERANDS_DEF-1:0]                      data_valid;
  } wb_entry_t;

  // Width of a flattened entry: inst_id on top, then one
  // {prn, data, data_valid} slot per operand.
  function automatic int entry_bits(input int id_bits, input int prn_bits, input int ops);
    return id_bits + ops * (prn_bits + DATA_BITS + 1);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// FU result / writeback bus of the arbiter. master = FUs + ROB/PRF side,
// slave = the arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int INST_ID_BITS = INST_ID_BITS_DEF,
  parameter int PRN_BITS     = PRN_BITS_DEF,
  parameter int MAX_OPERANDS = MAX_OPERANDS_DEF,
  parameter int FU_COUNT     = FU_COUNT_DEF
);

  logic [FU_COUNT-1:0]      fu_out_valid;
  logic [INST_ID_BITS-1:0]  fu_out_inst_id    [FU_COUNT];
  logic [PRN_BITS-1:0]      fu_out_prn        [FU_COUNT][MAX_OPERANDS];
  logic [DATA_BITS-1:0]     fu_out_data       [FU_COUNT][MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0]  fu_out_data_valid [FU_COUNT];
  logic [FU_COUNT-1:0]      fu_hold;

  logic                     wb_ready;
  logic [MAX_OPERANDS-1:0]  prf_write_enable;
  logic [PRN_BITS-1:0]      prf_write_prn  [MAX_OPERANDS];
  logic [DATA_BITS-1:0]     prf_write_data [MAX_OPERANDS];
  logic                     rob_done_valid;
  logic [INST_ID_BITS-1:0]  rob_done_inst_id;
  logic                     overflow_err;

  modport master (
    output fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
    output wb_ready,
    input  fu_hold, prf_write_enable, prf_write_prn, prf_write_data,
    input  rob_done_valid, rob_done_inst_id, overflow_err
  );

  modport slave (
    input  fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
    input  wb_ready,
    output fu_hold, prf_write_enable, prf_write_prn, prf_write_data,
    output rob_done_valid, rob_done_inst_id, overflow_err
  );

endinterface

// File: rtl/wb_fifo.sv
// Per-FU result buffer. A push into a full buffer is accepted only when the
// head is popped in the same cycle; otherwise it is dropped and flagged.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             hold,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  // Status, handshake qualification and next-state of pointers/occupancy.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    hold     = (count_q >= (AW+1)'(DEPTH - 1));
    head     = mem_q[rd_ptr_q];
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    overflow = push & full & ~do_pop;

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through a valid occupancy.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers each FU's results and grants one buffered
// instruction per cycle to the ROB/PRF, round-robin across FUs.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int INST_ID_BITS = INST_ID_BITS_DEF,
  parameter int PRN_BITS     = PRN_BITS_DEF,
  parameter int MAX_OPERANDS = MAX_OPERANDS_DEF,
  parameter int FU_COUNT     = FU_COUNT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int SLOT_W  = PRN_BITS + DATA_BITS + 1;
  localparam int ENTRY_W = entry_bits(INST_ID_BITS, PRN_BITS, MAX_OPERANDS);
  localparam int ID_LSB  = MAX_OPERANDS * SLOT_W;
  localparam int FU_W    = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  logic [ENTRY_W-1:0] push_entry [FU_COUNT];
  logic [ENTRY_W-1:0] head_entry [FU_COUNT];
  logic [FU_COUNT-1:0] fifo_empty, fifo_hold, fifo_pop, fifo_ovf;

  logic [FU_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [FU_W-1:0] lock_idx_q, lock_idx_d;
  logic            ovf_q, ovf_d;

  logic [FU_W-1:0]    sel_idx, cand_idx;
  logic               found, grant_valid, grant_fire;
  int unsigned        cand;
  logic [ENTRY_W-1:0] sel_entry;

  // Flatten each FU's result fields into one FIFO entry.
  always_comb begin
    for (int unsigned f = 0; f < FU_COUNT; f++) begin
      push_entry[f] = '0;
      push_entry[f][ID_LSB +: INST_ID_BITS] = bus.fu_out_inst_id[f];
      for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
        push_entry[f][k*SLOT_W +: SLOT_W] =
          {bus.fu_out_prn[f][k], bus.fu_out_data[f][k], bus.fu_out_data_valid[f][k]};
      end
    end
  end

  for (genvar g = 0; g < FU_COUNT; g++) begin : g_fifo
    wb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.fu_out_valid[g]),
      .push_data (push_entry[g]),
      .pop       (fifo_pop[g]),
      .empty     (fifo_empty[g]),
      .hold      (fifo_hold[g]),
      .head      (head_entry[g]),
      .overflow  (fifo_ovf[g])
    );
  end

  // Round-robin pick starting after the last granted FU. A grant stalled by
  // wb_ready=0 is latched so a later push into a higher-priority FIFO cannot
  // swap the presented entry underneath the ROB.
  always_comb begin
    sel_idx  = rr_ptr_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= FU_COUNT; i++) begin
      cand     = (32'(rr_ptr_q) + i) % FU_COUNT;
      cand_idx = FU_W'(cand);
      if (!found && !fifo_empty[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
    if (lock_q) begin
      sel_idx = lock_idx_q;
    end
    grant_valid = (fifo_empty != '1);
    grant_fire  = grant_valid & bus.wb_ready;
    sel_entry   = grant_valid ? head_entry[sel_idx] : '0;
  end

  // Drive the ROB/PRF outputs from the selected head and pop it on accept.
  always_comb begin
    bus.rob_done_valid   = grant_valid;
    bus.rob_done_inst_id = sel_entry[ID_LSB +: INST_ID_BITS];
    bus.prf_write_enable = '0;
    for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
      {bus.prf_write_prn[k], bus.prf_write_data[k], bus.prf_write_enable[k]} =
        sel_entry[k*SLOT_W +: SLOT_W];
    end
    bus.fu_hold      = fifo_hold;
    bus.overflow_err = ovf_q;
    fifo_pop         = '0;
    for (int unsigned f = 0; f < FU_COUNT; f++) begin
      fifo_pop[f] = grant_fire & (sel_idx == FU_W'(f));
    end
  end

  // Next-state for the round-robin pointer, stall lock and sticky overflow.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    ovf_d      = ovf_q | (|fifo_ovf);
    if (grant_fire) begin
      rr_ptr_d = sel_idx;
    end
    if (grant_valid && !bus.wb_ready) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end
  end

  // Arbitration state; reset points at the last FU so FU 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= FU_W'(FU_COUNT - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter at default geometry (4 FUs, depth 4,
// 3 operand slots). Expected grants go into a scoreboard queue when the
// stimulus is driven and are compared as the arbiter hands them to the ROB.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  wb_entry_t exp_q[$];

  wb_arbiter_if bus ();

  wb_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.fu_out_valid = '0;
    for (int f = 0; f < FU_COUNT_DEF; f++) begin
      bus.fu_out_inst_id[f]    = '0;
      bus.fu_out_data_valid[f] = '0;
      for (int k = 0; k < MAX_OPERANDS_DEF; k++) begin
        bus.fu_out_prn[f][k]  = '0;
        bus.fu_out_data[f][k] = '0;
      end
    end
  endtask

  // Drive one FU result and return the entry the ROB should later see.
  task automatic set_fu(input logic [1:0] fu, input logic [5:0] id, input logic [5:0] prn0,
                        input logic [63:0] d0, input logic [2:0] dv, output wb_entry_t e);
    bus.fu_out_valid[fu]      = 1'b1;
    bus.fu_out_inst_id[fu]    = id;
    bus.fu_out_data_valid[fu] = dv;
    e.inst_id    = id;
    e.data_valid = dv;
    for (int k = 0; k < MAX_OPERANDS_DEF; k++) begin
      bus.fu_out_prn[fu][k]  = prn0 + 6'(k);
      bus.fu_out_data[fu][k] = d0 + 64'(k) * 64'h1000;
      e.prn[k]  = prn0 + 6'(k);
      e.data[k] = d0 + 64'(k) * 64'h1000;
    end
  endtask

  // Advance one clock; at the falling edge any accepted grant is checked
  // against the scoreboard head. Returns 1 time unit after the rising edge.
  task automatic cycle();
    wb_entry_t e;
    wb_entry_t act;
    @(negedge clk);
    if (!rst && bus.rob_done_valid && bus.wb_ready) begin
      act.inst_id    = bus.rob_done_inst_id;
      act.data_valid = bus.prf_write_enable;
      for (int k = 0; k < MAX_OPERANDS_DEF; k++) begin
        act.prn[k]  = bus.prf_write_prn[k];
        act.data[k] = bus.prf_write_data[k];
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got id=%0d, required no grant", act.inst_id);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL grant: got id=%0d prn=%h data=%h en=%b, required id=%0d prn=%h data=%h en=%b",
                   act.inst_id, act.prn, act.data, act.data_valid,
                   e.inst_id, e.prn, e.data, e.data_valid);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wb_ready = 1'b0;
    clear_inputs();
    exp_q.delete();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wb_ready = 1'b0;
    clear_inputs();
    cycle();
    cycle();
    checks++;
    if (bus.rob_done_valid !== 1'b0 || bus.rob_done_inst_id !== '0) begin
      errors++;
      $display("FAIL reset_rob: got valid=%b id=%0d, required 0 0", bus.rob_done_valid, bus.rob_done_inst_id);
    end
    checks++;
    if (bus.fu_hold !== 4'b0000 || bus.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got hold=%b ovf=%b, required 0000 0", bus.fu_hold, bus.overflow_err);
    end
    checks++;
    if (bus.prf_write_enable !== 3'b000 || bus.prf_write_prn[0] !== '0 || bus.prf_write_data[0] !== '0) begin
      errors++;
      $display("FAIL reset_prf: got en=%b prn0=%0d data0=%h, required 0", bus.prf_write_enable,
               bus.prf_write_prn[0], bus.prf_write_data[0]);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (bus.rob_done_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got valid=%b, required 0", bus.rob_done_valid);
    end
  endtask

  task automatic test_single();
    wb_entry_t e;
    do_reset();
    bus.wb_ready = 1'b1;
    set_fu(2'd1, 6'd5, 6'd12, 64'hAB, 3'b101, e);
    exp_q.push_back(e);
    cycle();
    clear_inputs();
    checks++;
    if (bus.rob_done_valid !== 1'b1 || bus.rob_done_inst_id !== 6'd5) begin
      errors++;
      $display("FAIL single_present: got valid=%b id=%0d, required 1 5", bus.rob_done_valid, bus.rob_done_inst_id);
    end
    checks++;
    if (bus.prf_write_prn[0] !== 6'd12 || bus.prf_write_data[0] !== 64'hAB || bus.prf_write_enable !== 3'b101) begin
      errors++;
      $display("FAIL single_prf: got prn0=%0d data0=%h en=%b, required 12 ab 101",
               bus.prf_write_prn[0], bus.prf_write_data[0], bus.prf_write_enable);
    end
    cycle();
    checks++;
    if (bus.rob_done_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_once: got valid=%b pending=%0d, required 0 0", bus.rob_done_valid, exp_q.size());
    end
  endtask

  task automatic test_all_fus();
    wb_entry_t e;
    do_reset();
    bus.wb_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      set_fu(2'(f), 6'(10 + f), 6'(f * 8), 64'h100 * 64'(f + 1), 3'b111, e);
      exp_q.push_back(e);
    end
    cycle();
    clear_inputs();
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (bus.rob_done_valid !== 1'b1 || bus.rob_done_inst_id !== 6'(10 + n)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got valid=%b id=%0d, required 1 %0d", n,
                 bus.rob_done_valid, bus.rob_done_inst_id, 10 + n);
      end
      cycle();
    end
    checks++;
    if (bus.rob_done_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_done: got valid=%b pending=%0d, required 0 0", bus.rob_done_valid, exp_q.size());
    end
  endtask

  task automatic test_hold();
    wb_entry_t e20, e21, e22, e23;
    int n;
    do_reset();
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_fu(2'd2, 6'd20, 6'd1, 64'h2000, 3'b011, e20);
        1: set_fu(2'd2, 6'd21, 6'd4, 64'h2100, 3'b110, e21);
        default: begin
          set_fu(2'd2, 6'd22, 6'd7, 64'h2200, 3'b001, e22);
          set_fu(2'd0, 6'd23, 6'd9, 64'h2300, 3'b111, e23);
          // FU2 head is stalled, then round-robin continues from FU3.
          exp_q.push_back(e20);
          exp_q.push_back(e23);
          exp_q.push_back(e21);
          exp_q.push_back(e22);
        end
      endcase
      cycle();
      clear_inputs();
      checks++;
      if (bus.fu_hold !== ((i == 2) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL hold_after_push[%0d]: got hold=%b, required %b", i, bus.fu_hold,
                 (i == 2) ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (bus.rob_done_valid !== 1'b1 || bus.rob_done_inst_id !== 6'd20 || bus.prf_write_prn[0] !== 6'd1) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got valid=%b id=%0d prn0=%0d, required 1 20 1", i,
                 bus.rob_done_valid, bus.rob_done_inst_id, bus.prf_write_prn[0]);
      end
    end
    cycle();
    checks++;
    if (bus.rob_done_inst_id !== 6'd20 || bus.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL hold_locked: got id=%0d ovf=%b, required 20 0", bus.rob_done_inst_id, bus.overflow_err);
    end
    bus.wb_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.rob_done_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_drain: got pending=%0d valid=%b, required 0 0", exp_q.size(), bus.rob_done_valid);
    end
  endtask

  task automatic test_overflow();
    wb_entry_t e;
    int n;
    do_reset();
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_fu(2'd0, 6'(30 + i), 6'(20 + i), 64'h3000 + 64'(i), 3'b111, e);
      if (i < 4) exp_q.push_back(e);
      cycle();
      clear_inputs();
      checks++;
      if (bus.overflow_err !== (i == 4) || bus.fu_hold[0] !== (i >= 2)) begin
        errors++;
        $display("FAIL ovf_push[%0d]: got ovf=%b hold0=%b, required %b %b", i,
                 bus.overflow_err, bus.fu_hold[0], (i == 4), (i >= 2));
      end
    end
    bus.wb_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.rob_done_valid !== 1'b0 || bus.overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: got pending=%0d valid=%b ovf=%b, required 0 0 1",
               exp_q.size(), bus.rob_done_valid, bus.overflow_err);
    end
  endtask

  task automatic test_full_pushpop();
    wb_entry_t e;
    int n;
    do_reset();
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_fu(2'd3, 6'(40 + i), 6'(30 + i), 64'h4000 + 64'(i), 3'b010, e);
      exp_q.push_back(e);
      cycle();
      clear_inputs();
    end
    checks++;
    if (bus.fu_hold !== 4'b1000 || bus.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got hold=%b ovf=%b, required 1000 0", bus.fu_hold, bus.overflow_err);
    end
    bus.wb_ready = 1'b1;
    set_fu(2'd3, 6'd7, 6'd50, 64'h7777, 3'b111, e);
    exp_q.push_back(e);
    cycle();
    clear_inputs();
    bus.wb_ready = 1'b0;
    checks++;
    if (bus.overflow_err !== 1'b0 || bus.fu_hold[3] !== 1'b1 || bus.rob_done_inst_id !== 6'd41) begin
      errors++;
      $display("FAIL full_pushpop: got ovf=%b hold3=%b id=%0d, required 0 1 41",
               bus.overflow_err, bus.fu_hold[3], bus.rob_done_inst_id);
    end
    bus.wb_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || n != 4 || bus.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: got pending=%0d cycles=%0d ovf=%b, required 0 4 0",
               exp_q.size(), n, bus.overflow_err);
    end
  endtask

  task automatic test_mid_reset();
    wb_entry_t e;
    do_reset();
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_fu(2'd0, 6'(50 + i), 6'(i), 64'h5000, 3'b111, e);
      if (i == 0) set_fu(2'd1, 6'd60, 6'd3, 64'h6000, 3'b111, e);
      cycle();
      clear_inputs();
    end
    checks++;
    if (bus.overflow_err !== 1'b1 || bus.rob_done_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got ovf=%b valid=%b, required 1 1", bus.overflow_err, bus.rob_done_valid);
    end
    rst = 1'b1;
    set_fu(2'd2, 6'd61, 6'd5, 64'h6100, 3'b111, e);
    exp_q.delete();
    cycle();
    rst = 1'b0;
    clear_inputs();
    checks++;
    if (bus.rob_done_valid !== 1'b0 || bus.fu_hold !== 4'b0000 || bus.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got valid=%b hold=%b ovf=%b, required 0 0000 0",
               bus.rob_done_valid, bus.fu_hold, bus.overflow_err);
    end
    cycle();
    checks++;
    if (bus.rob_done_valid !== 1'b0 || bus.prf_write_enable !== 3'b000) begin
      errors++;
      $display("FAIL midrst_discard: got valid=%b en=%b, required 0 000", bus.rob_done_valid, bus.prf_write_enable);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_all_fus();
    test_hold();
    test_overflow();
    test_full_pushpop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
